// File: rtl/operand_entry_reg_if.sv
// Keypad-side bundle for operand_entry_reg: entry strobes and operator handshake in,
// operand and status out. The master drives the strobes and the slave is the register.
interface operand_entry_reg_if #(
    parameter int DIGITS = 4,
    parameter int OPW    = 2
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  enable;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  digit_valid;
    logic [3:0]            digit;
    logic                  backspace;
    logic                  op_strobe;
    logic [OPW-1:0]        op_code;
    logic                  op_ack;
    logic [4*DIGITS-1:0]   Q;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  bad_digit;
    logic [OPW-1:0]        op_q;
    logic                  op_pending;

    modport master (
        output enable, clear, load, load_val, digit_valid, digit, backspace,
               op_strobe, op_code, op_ack,
        input  Q, count, empty, full, overflow, bad_digit, op_q, op_pending
    );

    modport slave (
        input  enable, clear, load, load_val, digit_valid, digit, backspace,
               op_strobe, op_code, op_ack,
        output Q, count, empty, full, overflow, bad_digit, op_q, op_pending
    );
endinterface

// File: rtl/operand_entry_reg.sv
// BCD operand entry register with pending-operator latch for the calculator datapath.
// Define OPERAND_ENTRY_BKSP_EN to build the backspace logic; otherwise backspace is ignored.
module operand_entry_reg #(
    parameter int DIGITS = 4,
    parameter int EN_POL = 1,
    parameter int OPW    = 2
) (
    input  logic                CLK,
    input  logic                reset,
    operand_entry_reg_if.slave  bus
);
    localparam int             W       = 4 * DIGITS;
    localparam int             CW      = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIGITS);
    localparam logic           EN_LVL  = (EN_POL != 0);

    typedef enum logic [1:0] {EMPTY, ENTRY, FULL, FRESH} state_t;

    state_t          state;
    logic [W-1:0]    q_r, q_nxt;
    logic [CW-1:0]   cnt_r, cnt_nxt;
    logic            ovf_r, ovf_nxt;
    logic            fresh, fresh_nxt;
    logic            bad_r, bad_nxt;
    logic [OPW-1:0]  op_r;
    logic            pend_r;
    logic            en;
    logic            bksp;

    assign en    = (bus.enable == EN_LVL);
    assign fresh = (state == FRESH);

`ifdef OPERAND_ENTRY_BKSP_EN
    assign bksp = bus.backspace;
`else
    assign bksp = 1'b0;
`endif

    // Significant digit count of a loaded value: position of the top nonzero nibble.
    function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] != 4'd0) n = CW'(i + 1);
        return n;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        q_nxt     = q_r;
        cnt_nxt   = cnt_r;
        ovf_nxt   = ovf_r;
        fresh_nxt = fresh;
        bad_nxt   = 1'b0;
        if (bus.clear) begin
            q_nxt     = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            fresh_nxt = 1'b0;
        end else if (bus.load) begin
            q_nxt     = bus.load_val;
            cnt_nxt   = sig_digits(bus.load_val);
            ovf_nxt   = 1'b0;
            fresh_nxt = 1'b0;
        end else if (bksp) begin
            if (cnt_r != '0 && !fresh) begin
                q_nxt   = q_r >> 4;
                cnt_nxt = cnt_r - 1'b1;
            end
        end else if (bus.digit_valid) begin
            if (bus.digit > 4'd9) begin
                bad_nxt = 1'b1;
            end else if (fresh) begin
                q_nxt     = W'(bus.digit);
                cnt_nxt   = CW'(bus.digit != 4'd0);
                ovf_nxt   = 1'b0;
                fresh_nxt = 1'b0;
            end else if (cnt_r == '0 && bus.digit == 4'd0) begin
                q_nxt = q_r;
            end else if (cnt_r < CNT_MAX) begin
                q_nxt   = {q_r[W-5:0], bus.digit};
                cnt_nxt = cnt_r + 1'b1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
        // The operand action above lands first; a strobe then marks the next digit as a new operand.
        if (bus.op_strobe) fresh_nxt = 1'b1;
    end

    always_ff @(posedge CLK) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (reset) begin
            state  <= EMPTY;
            q_r    <= '0;
            cnt_r  <= '0;
            ovf_r  <= 1'b0;
            bad_r  <= 1'b0;
            op_r   <= '0;
            pend_r <= 1'b0;
        end else if (en) begin
            q_r   <= q_nxt;
            cnt_r <= cnt_nxt;
            ovf_r <= ovf_nxt;
            bad_r <= bad_nxt;
            if (fresh_nxt)              state <= FRESH;
            else if (cnt_nxt == '0)     state <= EMPTY;
            else if (cnt_nxt == CNT_MAX) state <= FULL;
            else                        state <= ENTRY;
            if (bus.op_strobe) begin
                op_r   <= bus.op_code;
                pend_r <= 1'b1;
            end else if (bus.op_ack) begin
                pend_r <= 1'b0;
            end
        end else begin
            bad_r <= 1'b0;
        end
    end

    assign bus.Q          = q_r;
    assign bus.count      = cnt_r;
    assign bus.empty      = (cnt_r == '0);
    assign bus.full       = (cnt_r == CNT_MAX);
    assign bus.overflow   = ovf_r;
    assign bus.bad_digit  = bad_r;
    assign bus.op_q       = op_r;
    assign bus.op_pending = pend_r;
endmodule

// File: tb/tb_operand_entry_reg.sv
// Directed bench for operand_entry_reg: an active-high-enable instance for the entry rules
// and an active-low-enable instance for enable polarity and reset override.
module tb_operand_entry_reg;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    operand_entry_reg_if #(.DIGITS(4), .OPW(2)) a ();
    operand_entry_reg_if #(.DIGITS(4), .OPW(2)) b ();

    operand_entry_reg #(.DIGITS(4), .EN_POL(1), .OPW(2)) u_dut_a (
        .CLK   (clk),
        .reset (reset),
        .bus   (a)
    );

    operand_entry_reg #(.DIGITS(4), .EN_POL(0), .OPW(2)) u_dut_b (
        .CLK   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic press_a(input logic [3:0] d);
        a.digit_valid = 1'b1;
        a.digit       = d;
        tick();
        a.digit_valid = 1'b0;
    endtask

    task automatic press_b(input logic [3:0] d);
        b.digit_valid = 1'b1;
        b.digit       = d;
        tick();
        b.digit_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a.enable = 1'b1; a.clear = 0; a.load = 0; a.load_val = '0; a.digit_valid = 0;
        a.digit = '0; a.backspace = 0; a.op_strobe = 0; a.op_code = '0; a.op_ack = 0;
        b.enable = 1'b0; b.clear = 0; b.load = 0; b.load_val = '0; b.digit_valid = 0;
        b.digit = '0; b.backspace = 0; b.op_strobe = 0; b.op_code = '0; b.op_ack = 0;
        tick();
        tick();
        check("rst_q",       32'(a.Q),          32'h0);
        check("rst_count",   32'(a.count),      32'd0);
        check("rst_empty",   32'(a.empty),      32'd1);
        check("rst_full",    32'(a.full),       32'd0);
        check("rst_ovf",     32'(a.overflow),   32'd0);
        check("rst_bad",     32'(a.bad_digit),  32'd0);
        check("rst_op_q",    32'(a.op_q),       32'd0);
        check("rst_pending", 32'(a.op_pending), 32'd0);
        reset = 1'b0;

        press_a(4'd1); press_a(4'd2); press_a(4'd3);
        check("d123_q",     32'(a.Q),     32'h0123);
        check("d123_count", 32'(a.count), 32'd3);
        check("d123_empty", 32'(a.empty), 32'd0);
        check("d123_full",  32'(a.full),  32'd0);
        press_a(4'd4);
        check("d1234_q",    32'(a.Q),        32'h1234);
        check("d1234_full", 32'(a.full),     32'd1);
        check("d1234_ovf",  32'(a.overflow), 32'd0);
        press_a(4'd5);
        check("drop_q",     32'(a.Q),        32'h1234);
        check("drop_count", 32'(a.count),    32'd4);
        check("drop_ovf",   32'(a.overflow), 32'd1);
        a.clear = 1'b1; tick(); a.clear = 1'b0;
        check("clr_q",     32'(a.Q),        32'h0);
        check("clr_count", 32'(a.count),    32'd0);
        check("clr_ovf",   32'(a.overflow), 32'd0);
        check("clr_empty", 32'(a.empty),    32'd1);

        press_a(4'd0);
        check("lead0_count", 32'(a.count), 32'd0);
        press_a(4'd0); press_a(4'd7);
        check("d007_q",     32'(a.Q),     32'h0007);
        check("d007_count", 32'(a.count), 32'd1);
        a.backspace = 1'b1; tick();
`ifdef OPERAND_ENTRY_BKSP_EN
        check("bs1_q",     32'(a.Q),     32'h0);
        check("bs1_count", 32'(a.count), 32'd0);
`else
        check("bs1_q",     32'(a.Q),     32'h0007);
        check("bs1_count", 32'(a.count), 32'd1);
`endif
        tick(); a.backspace = 1'b0;
`ifdef OPERAND_ENTRY_BKSP_EN
        check("bs2_q",     32'(a.Q),     32'h0);
        check("bs2_count", 32'(a.count), 32'd0);
`else
        check("bs2_q",     32'(a.Q),     32'h0007);
        check("bs2_count", 32'(a.count), 32'd1);
`endif

        a.clear = 1'b1; tick(); a.clear = 1'b0;
        press_a(4'd1); press_a(4'd2);
        press_a(4'hA);
        check("bad_q",     32'(a.Q),         32'h0012);
        check("bad_pulse", 32'(a.bad_digit), 32'd1);
        tick();
        check("bad_end",   32'(a.bad_digit), 32'd0);

        a.load = 1'b1; a.load_val = 16'h0500; tick();
        check("ld500_q",     32'(a.Q),     32'h0500);
        check("ld500_count", 32'(a.count), 32'd3);
        a.load_val = 16'h0042; tick(); a.load = 1'b0;
        check("ld42_count", 32'(a.count), 32'd2);

        a.op_strobe = 1'b1; a.op_code = 2'd2; tick(); a.op_strobe = 1'b0;
        check("op_q_q",    32'(a.Q),          32'h0042);
        check("op_q",      32'(a.op_q),       32'd2);
        check("op_pend",   32'(a.op_pending), 32'd1);
        press_a(4'd5);
        check("fresh_q",     32'(a.Q),          32'h0005);
        check("fresh_count", 32'(a.count),      32'd1);
        check("fresh_pend",  32'(a.op_pending), 32'd1);
        a.op_ack = 1'b1; tick(); a.op_ack = 1'b0;
        check("ack_pend", 32'(a.op_pending), 32'd0);
        a.op_strobe = 1'b1; a.op_ack = 1'b1; a.op_code = 2'd1; tick();
        a.op_strobe = 1'b0; a.op_ack = 1'b0;
        check("both_pend", 32'(a.op_pending), 32'd1);
        check("both_op_q", 32'(a.op_q),       32'd1);

        press_a(4'd9);
        check("fresh0_q", 32'(a.Q), 32'h0009);
        a.op_strobe = 1'b1; a.op_code = 2'd3; press_a(4'd3); a.op_strobe = 1'b0;
        check("strobe_digit_q", 32'(a.Q), 32'h0093);
        press_a(4'd8);
        check("after_strobe_q", 32'(a.Q), 32'h0008);

        a.enable = 1'b0;
        press_a(4'd6);
        check("dis_q", 32'(a.Q), 32'h0008);
        press_a(4'hF);
        check("dis_bad", 32'(a.bad_digit), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("dis_rst_q",    32'(a.Q),          32'h0);
        check("dis_rst_op_q", 32'(a.op_q),       32'd0);
        check("dis_rst_pend", 32'(a.op_pending), 32'd0);
        check("dis_rst_emp",  32'(a.empty),      32'd1);

        press_b(4'd3); press_b(4'd4);
        check("nb_q", 32'(b.Q), 32'h0034);
        b.enable = 1'b1;
        press_b(4'd5);
        b.clear = 1'b1; tick(); b.clear = 1'b0;
        check("nb_hold_q",     32'(b.Q),     32'h0034);
        check("nb_hold_count", 32'(b.count), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("nb_rst_q",     32'(b.Q),         32'h0);
        check("nb_rst_count", 32'(b.count),     32'd0);
        check("nb_rst_empty", 32'(b.empty),     32'd1);
        check("nb_rst_ovf",   32'(b.overflow),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
